// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues word fetches to the instruction SRAM,
// buffers up to two {pc, inst} pairs for decode, and drops stale responses on a redirect.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h1c000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        br_taken,
   input  logic [31:0] br_target,
   output logic        inst_req,
   output logic [31:0] inst_addr,
   input  logic        inst_addr_ok,
   input  logic        inst_data_ok,
   input  logic [31:0] inst_rdata,
   output logic        fs_valid,
   output logic [31:0] fs_pc,
   output logic [31:0] fs_inst,
   input  logic        ds_ready
);

   logic [31:0] pc;
   logic [1:0]  outstanding;
   logic [1:0]  discard;
   logic [1:0]  fifo_count;

   // Tag FIFO: address of each accepted request, popped in order with its response.
   logic [31:0] tag_q [2];
   logic        tag_wr;
   logic        tag_rd;

   logic [31:0] fifo_pc   [2];
   logic [31:0] fifo_inst [2];
   logic        fifo_wr;
   logic        fifo_rd;

   logic [2:0]  credit;
   logic [1:0]  outstanding_next;
   logic        accept;
   logic        push;
   logic        pop;

   // Live requests plus buffered entries; discarded requests never need a slot.
   assign credit           = {1'b0, outstanding} - {1'b0, discard} + {1'b0, fifo_count};
   assign inst_req         = !reset && (credit < 3'd2) && (outstanding < 2'd2);
   assign inst_addr        = pc;
   assign accept           = inst_req && inst_addr_ok;
   assign outstanding_next = outstanding + {1'b0, accept} - {1'b0, inst_data_ok};

   assign fs_valid = (fifo_count != 2'd0);
   assign fs_pc    = fifo_pc[fifo_rd];
   assign fs_inst  = fifo_inst[fifo_rd];
   assign pop      = fs_valid && ds_ready;
   assign push     = inst_data_ok && !br_taken && (discard == 2'd0);

   always_ff @(posedge clk) begin
      // NOTE: every register here is state, so only non-blocking assignments are used;
      // a blocking write would let later statements see the new value within the same edge.
      if (reset) begin
         pc          <= RESET_PC;
         outstanding <= 2'd0;
         discard     <= 2'd0;
         fifo_count  <= 2'd0;
         tag_wr      <= 1'b0;
         tag_rd      <= 1'b0;
         fifo_wr     <= 1'b0;
         fifo_rd     <= 1'b0;
         // NOTE: the output buffer storage is cleared because fs_pc/fs_inst read it directly
         // and must be 0 out of reset; the tag storage is never observed empty, so it is not.
         for (int i = 0; i < 2; i++) begin
            fifo_pc[i]   <= 32'd0;
            fifo_inst[i] <= 32'd0;
         end
      end else begin
         outstanding <= outstanding_next;

         if (accept) begin
            tag_q[tag_wr] <= pc;
            tag_wr        <= !tag_wr;
         end
         if (inst_data_ok)
            tag_rd <= !tag_rd;

         if (push) begin
            fifo_pc[fifo_wr]   <= tag_q[tag_rd];
            fifo_inst[fifo_wr] <= inst_rdata;
         end

         if (br_taken) begin
            // Everything still in flight, including a request accepted this cycle, is stale.
            pc         <= br_target & ~32'd3;
            discard    <= outstanding_next;
            fifo_count <= 2'd0;
            fifo_wr    <= 1'b0;
            fifo_rd    <= 1'b0;
         end else begin
            if (accept)
               pc <= pc + 32'd4;
            if (inst_data_ok && (discard != 2'd0))
               discard <= discard - 2'd1;
            if (push)
               fifo_wr <= !fifo_wr;
            if (pop)
               fifo_rd <= !fifo_rd;
            fifo_count <= fifo_count + {1'b0, push} - {1'b0, pop};
         end
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: SRAM model with variable latency, scoreboard of
// expected {pc, inst} deliveries, a redirect vector table and hand-written corner cases.
module tb_fetch_stage;

   localparam logic [31:0] RESET_PC = 32'h1c000000;

   logic        clk = 1'b0;
   logic        reset;
   logic        br_taken;
   logic [31:0] br_target;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_addr_ok;
   logic        inst_data_ok;
   logic [31:0] inst_rdata;
   logic        fs_valid;
   logic [31:0] fs_pc;
   logic [31:0] fs_inst;
   logic        ds_ready;

   fetch_stage #(.RESET_PC(RESET_PC)) dut (
      .clk          (clk),
      .reset        (reset),
      .br_taken     (br_taken),
      .br_target    (br_target),
      .inst_req     (inst_req),
      .inst_addr    (inst_addr),
      .inst_addr_ok (inst_addr_ok),
      .inst_data_ok (inst_data_ok),
      .inst_rdata   (inst_rdata),
      .fs_valid     (fs_valid),
      .fs_pc        (fs_pc),
      .fs_inst      (fs_inst),
      .ds_ready     (ds_ready)
   );

   always #5 clk = ~clk;

   typedef struct { logic [31:0] pc; logic [31:0] inst; } item_t;
   typedef struct { int due; logic [31:0] data; } rsp_t;
   typedef struct { logic [31:0] target; logic [31:0] pc0; logic [31:0] pc1; } redir_t;

   item_t       exp_q[$];
   rsp_t        rsp_q[$];
   int          checks    = 0;
   int          errors    = 0;
   int          cyc       = 0;
   int          delivered = 0;
   int          live_out  = 0;
   logic [31:0] exp_addr  = RESET_PC;

   // Stimulus knobs read by tick() each cycle.
   logic        rst_v     = 1'b1;
   logic        br_v      = 1'b0;
   logic [31:0] tgt_v     = 32'd0;
   int          ready_pct = 100;
   int          ok_pct    = 100;
   int          lat_min   = 1;
   int          lat_max   = 1;
   int          br_pct    = 0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h5a5a0f0f;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Drive one cycle's inputs at the falling edge, then score what the next rising edge does.
   task automatic tick();
      rsp_t  r;
      item_t it;
      @(negedge clk);
      cyc++;
      reset        = rst_v;
      ds_ready     = ($urandom_range(99) < ready_pct);
      inst_addr_ok = ($urandom_range(99) < ok_pct);
      br_taken     = br_v || (!rst_v && ($urandom_range(99) < br_pct));
      br_target    = br_v ? tgt_v : $urandom();
      inst_data_ok = 1'b0;
      inst_rdata   = 32'hdeadbeef;
      if (rst_v)
         rsp_q.delete();
      else if (rsp_q.size() != 0 && rsp_q[0].due <= cyc) begin
         r            = rsp_q.pop_front();
         inst_data_ok = 1'b1;
         inst_rdata   = r.data;
      end
      #1;
      br_v = 1'b0;
      if (rst_v) begin
         exp_q.delete();
         live_out = 0;
         exp_addr = RESET_PC;
      end else begin
         if (fs_valid && ds_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_output: got pc %h, expected nothing", fs_pc);
            end else begin
               it = exp_q.pop_front();
               check("fs_pc", fs_pc, it.pc);
               check("fs_inst", fs_inst, it.inst);
               delivered++;
            end
         end
         if (inst_data_ok)
            live_out--;
         if (inst_req && inst_addr_ok) begin
            check("inst_addr", inst_addr, exp_addr);
            live_out++;
            check("outstanding_le_2", 32'(live_out <= 2), 32'd1);
            rsp_q.push_back('{cyc + int'($urandom_range(lat_max, lat_min)), mem_word(inst_addr)});
            if (!br_taken) begin
               exp_q.push_back('{exp_addr, mem_word(exp_addr)});
               check("buffer_le_2", 32'(exp_q.size() <= 2), 32'd1);
            end
            exp_addr += 32'd4;
         end
         if (br_taken) begin
            exp_q.delete();
            exp_addr = {br_target[31:2], 2'b00};
         end
      end
   endtask

   task automatic expect_next(input logic [31:0] pc_exp, input string name);
      for (int i = 0; i < 40; i++) begin
         tick();
         if (!rst_v && fs_valid && ds_ready) begin
            check(name, fs_pc, pc_exp);
            return;
         end
      end
      checks++;
      errors++;
      $display("FAIL %s: timeout, got nothing, expected %h", name, pc_exp);
   endtask

   task automatic do_reset(input int n);
      rst_v = 1'b1;
      repeat (n) tick();
      rst_v = 1'b0;
   endtask

   initial begin
      redir_t vec[4];
      int     base;
      bit     seen;

      vec[0] = '{32'h1c000103, 32'h1c000100, 32'h1c000104};
      vec[1] = '{32'h00000002, 32'h00000000, 32'h00000004};
      vec[2] = '{32'hfffffffd, 32'hfffffffc, 32'h00000000};
      vec[3] = '{32'h80000040, 32'h80000040, 32'h80000044};

      reset        = 1'b1;
      br_taken     = 1'b0;
      br_target    = 32'd0;
      inst_addr_ok = 1'b0;
      inst_data_ok = 1'b0;
      inst_rdata   = 32'd0;
      ds_ready     = 1'b0;

      // Reset values, first request, and two-cycle fetch latency.
      do_reset(3);
      check("rst_inst_req", 32'(inst_req), 32'd0);
      check("rst_fs_valid", 32'(fs_valid), 32'd0);
      check("rst_fs_pc", fs_pc, 32'd0);
      check("rst_fs_inst", fs_inst, 32'd0);
      tick();
      check("first_req", 32'(inst_req), 32'd1);
      check("first_addr", inst_addr, RESET_PC);
      check("lat_c0_valid", 32'(fs_valid), 32'd0);
      tick();
      check("lat_c1_valid", 32'(fs_valid), 32'd0);
      tick();
      check("lat_c2_valid", 32'(fs_valid), 32'd1);
      check("lat_c2_pc", fs_pc, RESET_PC);

      // Streaming with a 1-cycle SRAM.
      base = delivered;
      repeat (20) tick();
      check("stream_progress", 32'(delivered - base >= 10), 32'd1);

      // Backpressure: two entries buffered, issue stops, no loss on release.
      do_reset(2);
      ready_pct = 0;
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         tick();
         seen = fs_valid;
      end
      check("bp_valid_seen", 32'(seen), 32'd1);
      repeat (5) tick();
      check("bp_req_off", 32'(inst_req), 32'd0);
      check("bp_valid", 32'(fs_valid), 32'd1);
      check("bp_pc_held", fs_pc, RESET_PC);
      ready_pct = 100;
      expect_next(RESET_PC, "bp_release_0");
      expect_next(RESET_PC + 32'd4, "bp_release_1");

      // Redirect table with a 1-cycle SRAM streaming.
      for (int v = 0; v < 4; v++) begin
         repeat (3) tick();
         br_v  = 1'b1;
         tgt_v = vec[v].target;
         tick();
         expect_next(vec[v].pc0, "redir_pc0");
         expect_next(vec[v].pc1, "redir_pc1");
      end

      // Redirect with two requests in flight (3-cycle SRAM).
      lat_min = 3;
      lat_max = 3;
      do_reset(2);
      tick();
      tick();
      check("inflight_two", 32'(live_out), 32'd2);
      br_v  = 1'b1;
      tgt_v = 32'h1c000103;
      tick();
      check("inflight_no_req", 32'(inst_req), 32'd0);
      expect_next(32'h1c000100, "inflight_pc0");
      expect_next(32'h1c000104, "inflight_pc1");

      // Redirect coinciding with a response and an accept.
      lat_min = 1;
      lat_max = 1;
      do_reset(2);
      tick();
      br_v  = 1'b1;
      tgt_v = 32'h20000010;
      tick();
      check("same_cycle_all", 32'(inst_req && inst_addr_ok && inst_data_ok), 32'd1);
      expect_next(32'h20000010, "same_cycle_first");

      // Variable latency, random accept stalls, random backpressure and redirects.
      lat_max   = 4;
      ok_pct    = 60;
      ready_pct = 70;
      br_pct    = 3;
      base      = delivered;
      repeat (400) tick();
      br_pct    = 0;
      ok_pct    = 100;
      ready_pct = 100;
      repeat (20) tick();
      check("random_progress", 32'(delivered - base >= 20), 32'd1);

      // Reset with a full output buffer.
      lat_max   = 1;
      ready_pct = 0;
      repeat (10) tick();
      check("full_valid", 32'(fs_valid), 32'd1);
      check("full_req_off", 32'(inst_req), 32'd0);
      rst_v = 1'b1;
      tick();
      check("midrst_req0", 32'(inst_req), 32'd0);
      tick();
      check("midrst_req1", 32'(inst_req), 32'd0);
      check("midrst_valid", 32'(fs_valid), 32'd0);
      rst_v     = 1'b0;
      ready_pct = 100;
      tick();
      check("restart_req", 32'(inst_req), 32'd1);
      check("restart_addr", inst_addr, RESET_PC);
      expect_next(RESET_PC, "restart_pc0");
      expect_next(RESET_PC + 32'd4, "restart_pc1");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion, expected finish within time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
